// File: rtl/xadac_pkg.sv
// Shared widths and payload types of the xadac accelerator interface.
package xadac_pkg;
    localparam int VecDataWidth = 32;
    localparam int IdWidth      = 4;
    localparam int InstrWidth   = 32;
    localparam int NumVRegs     = 32;

    typedef struct packed {
        logic [IdWidth-1:0]    id;
        logic [InstrWidth-1:0] instr;
    } dec_req_t;

    typedef struct packed {
        logic [IdWidth-1:0] id;
        logic               accept;
        logic               vd_clobber;
    } dec_rsp_t;

    typedef struct packed {
        logic [IdWidth-1:0]                id;
        logic [InstrWidth-1:0]             instr;
        logic [1:0][31:0]                  rs_data;
        logic [2:0][VecDataWidth-1:0]      vs_data;
    } exe_req_t;

    typedef struct packed {
        logic [IdWidth-1:0]      id;
        logic [4:0]              vd_addr;
        logic [VecDataWidth-1:0] vd_data;
    } exe_rsp_t;
endpackage

// File: rtl/xadac_if.sv
// xadac initiator/responder bundle: decode and execute phases, each a req/rsp pair.
interface xadac_if;
    import xadac_pkg::*;

    logic     dec_req_valid;
    logic     dec_req_ready;
    dec_req_t dec_req;
    logic     dec_rsp_valid;
    logic     dec_rsp_ready;
    dec_rsp_t dec_rsp;
    logic     exe_req_valid;
    logic     exe_req_ready;
    exe_req_t exe_req;
    logic     exe_rsp_valid;
    logic     exe_rsp_ready;
    exe_rsp_t exe_rsp;

    modport mst (
        output dec_req_valid, dec_req, dec_rsp_ready, exe_req_valid, exe_req, exe_rsp_ready,
        input  dec_req_ready, dec_rsp_valid, dec_rsp, exe_req_ready, exe_rsp_valid, exe_rsp
    );

    modport slv (
        input  dec_req_valid, dec_req, dec_rsp_ready, exe_req_valid, exe_req, exe_rsp_ready,
        output dec_req_ready, dec_rsp_valid, dec_rsp, exe_req_ready, exe_rsp_valid, exe_rsp
    );
endinterface

// File: rtl/xadac_issue.sv
// xadac initiator: issues one offloaded vector instruction at a time through the
// decode and execute phases and writes results back into a local 32-entry VRF.
module xadac_issue
    import xadac_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    xadac_if.mst                    mst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [IdWidth-1:0]      in_id,
    input  logic [InstrWidth-1:0]   in_instr,
    input  logic [1:0][31:0]        in_rs_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [IdWidth-1:0]      out_id,
    output logic                    out_accept,
    output logic                    out_err,
    input  logic                    vrf_we,
    input  logic [4:0]              vrf_addr,
    input  logic [VecDataWidth-1:0] vrf_wdata,
    output logic [VecDataWidth-1:0] vrf_rdata
);

    typedef enum logic [1:0] {IDLE, DEC, EXE, DONE} state_t;

    state_t                       state, state_nxt;
    logic [IdWidth-1:0]           id_q;
    logic [InstrWidth-1:0]        instr_q;
    logic [1:0][31:0]             rs_q;
    logic [2:0][VecDataWidth-1:0] vs_q;
    logic                         req_done, rsp_done, clobber_q, accept_q, err_q;
    logic [VecDataWidth-1:0]      vrf [NumVRegs];

    logic               in_hs, dec_req_hs, dec_rsp_hs, exe_req_hs, exe_rsp_hs;
    logic               req_done_nxt, rsp_done_nxt, phase_done, accept_now, rsp_hs;
    logic [IdWidth-1:0] rsp_id;

    assign in_hs      = in_valid & in_ready;
    assign dec_req_hs = mst.dec_req_valid & mst.dec_req_ready;
    assign dec_rsp_hs = mst.dec_rsp_valid & mst.dec_rsp_ready;
    assign exe_req_hs = mst.exe_req_valid & mst.exe_req_ready;
    assign exe_rsp_hs = mst.exe_rsp_valid & mst.exe_rsp_ready;
    assign accept_now = dec_rsp_hs ? mst.dec_rsp.accept : accept_q;
    assign phase_done = req_done_nxt & rsp_done_nxt;

    // Both phases share one req/rsp flag pair; a phase ends once both handshakes are seen.
    always_comb begin
        req_done_nxt = req_done;
        rsp_done_nxt = rsp_done;
        rsp_hs       = 1'b0;
        rsp_id       = mst.dec_rsp.id;
        case (state)
            DEC: begin
                req_done_nxt = req_done | dec_req_hs;
                rsp_done_nxt = rsp_done | dec_rsp_hs;
                rsp_hs       = dec_rsp_hs;
            end
            EXE: begin
                req_done_nxt = req_done | exe_req_hs;
                rsp_done_nxt = rsp_done | exe_rsp_hs;
                rsp_hs       = exe_rsp_hs;
                rsp_id       = mst.exe_rsp.id;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_hs) state_nxt = DEC;
            DEC:  if (phase_done) state_nxt = accept_now ? EXE : DONE;
            EXE:  if (phase_done) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready          = (state == IDLE) & ~rst;
        mst.dec_req_valid = (state == DEC) & ~req_done;
        mst.dec_rsp_ready = (state == DEC) & ~rsp_done;
        mst.exe_req_valid = (state == EXE) & ~req_done;
        mst.exe_rsp_ready = (state == EXE) & ~rsp_done;
        mst.dec_req.id    = id_q;
        mst.dec_req.instr = instr_q;
        mst.exe_req.id      = id_q;
        mst.exe_req.instr   = instr_q;
        mst.exe_req.rs_data = rs_q;
        mst.exe_req.vs_data = vs_q;
        out_valid  = (state == DONE);
        out_id     = id_q;
        out_accept = accept_q;
        out_err    = err_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_q      <= '0;
            instr_q   <= '0;
            rs_q      <= '0;
            vs_q      <= '0;
            req_done  <= 1'b0;
            rsp_done  <= 1'b0;
            clobber_q <= 1'b0;
            accept_q  <= 1'b0;
            err_q     <= 1'b0;
        end else if (in_hs) begin
            id_q      <= in_id;
            instr_q   <= in_instr;
            rs_q      <= in_rs_data;
            req_done  <= 1'b0;
            rsp_done  <= 1'b0;
            clobber_q <= 1'b0;
            accept_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            req_done <= req_done_nxt & ~phase_done;
            rsp_done <= rsp_done_nxt & ~phase_done;
            if (rsp_hs && (rsp_id != id_q)) err_q <= 1'b1;
            if (dec_rsp_hs) begin
                accept_q  <= mst.dec_rsp.accept;
                clobber_q <= mst.dec_rsp.vd_clobber;
            end
            // Operands are captured on entry to EXE so they cannot move while exe_req is pending.
            if ((state == DEC) && phase_done && accept_now) begin
                vs_q[0] <= vrf[instr_q[19:15]];
                vs_q[1] <= vrf[instr_q[24:20]];
                vs_q[2] <= vrf[instr_q[11:7]];
            end
            if (out_valid && out_ready) begin
                err_q    <= 1'b0;
                accept_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NumVRegs; i++) vrf[i] <= '0;
            vrf_rdata <= '0;
        end else begin
            if ((state == IDLE) && vrf_we)
                vrf[vrf_addr] <= vrf_wdata;
            else if ((state == EXE) && exe_rsp_hs && clobber_q)
                vrf[mst.exe_rsp.vd_addr] <= mst.exe_rsp.vd_data;
            vrf_rdata <= vrf[vrf_addr];
        end
    end

endmodule

// File: tb/tb_xadac_issue.sv
// Bench for xadac_issue: a stub responder, a VRF reference model and a completion scoreboard.
module tb_xadac_issue;
    import xadac_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic                    in_valid, in_ready;
    logic [IdWidth-1:0]      in_id;
    logic [31:0]             in_instr;
    logic [1:0][31:0]        in_rs_data;
    logic                    out_valid, out_ready;
    logic [IdWidth-1:0]      out_id;
    logic                    out_accept, out_err;
    logic                    vrf_we;
    logic [4:0]              vrf_addr;
    logic [VecDataWidth-1:0] vrf_wdata, vrf_rdata;

    xadac_if xif ();

    xadac_issue dut (
        .clk(clk), .rst(rst), .mst(xif),
        .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_instr(in_instr),
        .in_rs_data(in_rs_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_id(out_id), .out_accept(out_accept), .out_err(out_err),
        .vrf_we(vrf_we), .vrf_addr(vrf_addr), .vrf_wdata(vrf_wdata), .vrf_rdata(vrf_rdata)
    );

    typedef struct {
        logic [IdWidth-1:0] id;
        logic               accept;
        logic               err;
    } exp_t;

    exp_t                    sbq[$];
    logic [VecDataWidth-1:0] mvrf [NumVRegs];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Completion monitor: every out handshake must match the oldest issued instruction.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("stale_completion", 64'(out_valid), 64'd0);
                end else begin
                    e = sbq.pop_front();
                    chk("out_id", 64'(out_id), 64'(e.id));
                    chk("out_accept", 64'(out_accept), 64'(e.accept));
                    chk("out_err", 64'(out_err), 64'(e.err));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic slv_idle();
        xif.dec_req_ready = 1'b0;
        xif.dec_rsp_valid = 1'b0;
        xif.dec_rsp       = '0;
        xif.exe_req_ready = 1'b0;
        xif.exe_rsp_valid = 1'b0;
        xif.exe_rsp       = '0;
        out_ready         = 1'b0;
        in_valid          = 1'b0;
        vrf_we            = 1'b0;
    endtask

    function automatic logic [31:0] mk(input logic [4:0] vd, input logic [4:0] vs1, input logic [4:0] vs2);
        return {7'd0, vs2, vs1, 3'd0, vd, 7'h0b};
    endfunction

    task automatic host_write(input logic [4:0] a, input logic [31:0] d);
        vrf_we = 1'b1; vrf_addr = a; vrf_wdata = d;
        mvrf[a] = d;
        tick();
        vrf_we = 1'b0;
    endtask

    task automatic read_model(input logic [4:0] a);
        vrf_addr = a;
        tick();
        chk("vrf_read", 64'(vrf_rdata), 64'(mvrf[a]));
    endtask

    task automatic read_const(input string name, input logic [4:0] a, input logic [31:0] d);
        vrf_addr = a;
        tick();
        chk(name, 64'(vrf_rdata), 64'(d));
    endtask

    task automatic run_txn(
        input logic [IdWidth-1:0] id, input logic [31:0] instr,
        input logic [31:0] rs0, input logic [31:0] rs1,
        input logic acc, input logic clob,
        input logic [IdWidth-1:0] dec_rid, input logic [IdWidth-1:0] exe_rid,
        input int dec_dly, input int exe_dly, input int out_hold,
        input logic lock_we, input logic host_same, input logic [31:0] hs_data,
        input int exp_lat);
        logic [31:0] e0, e1, e2, vd;
        logic [4:0]  a0, a1, a2;
        logic        err_e, done, dq, dp, eq, ep, oq, ev, ov;
        logic        stable_bad, dec_bad, busy_bad, lock_done, seen;
        int          cyc, dreq_cyc, ereq_cyc, n_dq, n_dp, n_eq, n_ep, evcnt, ovcnt, first_out, hs_cyc;
        exe_req_t    cap;
        a0 = instr[19:15]; a1 = instr[24:20]; a2 = instr[11:7];
        in_valid = 1'b1; in_id = id; in_instr = instr;
        in_rs_data[0] = rs0; in_rs_data[1] = rs1;
        if (host_same) begin
            vrf_we = 1'b1; vrf_addr = a0; vrf_wdata = hs_data;
            mvrf[a0] = hs_data;
        end
        chk("in_ready_idle", 64'(in_ready), 64'd1);
        e0 = mvrf[a0]; e1 = mvrf[a1]; e2 = mvrf[a2];
        vd = e0 * e1 + e2;
        err_e = (dec_rid != id) || (acc && (exe_rid != id));
        sbq.push_back('{id, acc, err_e});
        if (acc && clob) mvrf[a2] = vd;
        tick();
        in_valid = 1'b0; vrf_we = 1'b0;
        done = 0; stable_bad = 0; dec_bad = 0; busy_bad = 0; lock_done = 0; seen = 0;
        cyc = 1; dreq_cyc = -1; ereq_cyc = -1;
        n_dq = 0; n_dp = 0; n_eq = 0; n_ep = 0; evcnt = 0; ovcnt = 0; first_out = -1; hs_cyc = -1;
        cap = '0;
        while (!done && cyc <= 100) begin
            xif.dec_req_ready = 1'b1;
            xif.dec_rsp_valid = (n_dp == 0) &&
                ((dreq_cyc >= 0 && (cyc - dreq_cyc) >= dec_dly) ||
                 (dreq_cyc < 0 && xif.dec_req_valid && dec_dly == 0));
            xif.dec_rsp.id = dec_rid; xif.dec_rsp.accept = acc; xif.dec_rsp.vd_clobber = clob;
            xif.exe_req_ready = (evcnt >= exe_dly);
            xif.exe_rsp_valid = (n_ep == 0) && (ereq_cyc >= 0 || (xif.exe_req_valid && xif.exe_req_ready));
            xif.exe_rsp.id = exe_rid; xif.exe_rsp.vd_addr = a2; xif.exe_rsp.vd_data = vd;
            out_ready = out_valid && (ovcnt >= out_hold);
            if (lock_we && !lock_done && xif.exe_req_valid) begin
                vrf_we = 1'b1; vrf_addr = a0; vrf_wdata = ~mvrf[a0];
                lock_done = 1;
            end
            if (out_valid) begin
                if (first_out < 0) first_out = cyc;
                if (in_ready) busy_bad = 1;
            end
            if (xif.dec_req_valid && (xif.dec_req.id != id || xif.dec_req.instr != instr)) dec_bad = 1;
            if (xif.exe_req_valid) begin
                if (!seen) begin cap = xif.exe_req; seen = 1; end
                else if (xif.exe_req != cap) stable_bad = 1;
            end
            dq = xif.dec_req_valid && xif.dec_req_ready;
            dp = xif.dec_rsp_valid && xif.dec_rsp_ready;
            eq = xif.exe_req_valid && xif.exe_req_ready;
            ep = xif.exe_rsp_valid && xif.exe_rsp_ready;
            oq = out_valid && out_ready;
            ev = xif.exe_req_valid; ov = out_valid;
            tick();
            vrf_we = 1'b0;
            if (dq) begin n_dq++; if (dreq_cyc < 0) dreq_cyc = cyc; end
            if (dp) n_dp++;
            if (eq) begin n_eq++; if (ereq_cyc < 0) ereq_cyc = cyc; end
            if (ep) n_ep++;
            if (ev) evcnt++;
            if (ov) ovcnt++;
            if (oq) begin done = 1; hs_cyc = cyc; end
            cyc++;
        end
        slv_idle();
        chk("txn_complete", 64'(done), 64'd1);
        chk("dec_req_hs_count", 64'(n_dq), 64'd1);
        chk("dec_rsp_hs_count", 64'(n_dp), 64'd1);
        chk("exe_req_hs_count", 64'(n_eq), acc ? 64'd1 : 64'd0);
        chk("exe_rsp_hs_count", 64'(n_ep), acc ? 64'd1 : 64'd0);
        chk("exe_req_seen", 64'(seen), 64'(acc));
        chk("dec_payload_ok", 64'(dec_bad), 64'd0);
        chk("exe_payload_stable", 64'(stable_bad), 64'd0);
        chk("in_ready_busy", 64'(busy_bad), 64'd0);
        if (acc && seen) begin
            chk("exe_vs0", 64'(cap.vs_data[0]), 64'(e0));
            chk("exe_vs1", 64'(cap.vs_data[1]), 64'(e1));
            chk("exe_vs2", 64'(cap.vs_data[2]), 64'(e2));
            chk("exe_rs0", 64'(cap.rs_data[0]), 64'(rs0));
            chk("exe_rs1", 64'(cap.rs_data[1]), 64'(rs1));
            chk("exe_id_instr", {28'd0, cap.id, cap.instr}, {28'd0, id, instr});
        end
        if (done) chk("out_hold_cycles", 64'(hs_cyc - first_out), 64'(out_hold));
        if (exp_lat >= 0) chk("latency", 64'(first_out), 64'(exp_lat));
    endtask

    task automatic reset_mid_exe(input logic [IdWidth-1:0] id, input logic [31:0] instr);
        logic hit;
        in_valid = 1'b1; in_id = id; in_instr = instr; in_rs_data = '0;
        tick();
        in_valid = 1'b0;
        hit = 0;
        for (int c = 0; c < 20 && !hit; c++) begin
            xif.dec_req_ready = 1'b1;
            xif.dec_rsp_valid = xif.dec_req_valid;
            xif.dec_rsp.id = id; xif.dec_rsp.accept = 1'b1; xif.dec_rsp.vd_clobber = 1'b1;
            xif.exe_req_ready = 1'b0;
            if (xif.exe_req_valid) begin
                rst = 1'b1;
                #1;
                chk("rst_in_ready", 64'(in_ready), 64'd0);
                chk("rst_out_valid", 64'(out_valid), 64'd0);
                chk("rst_out_accept", 64'(out_accept), 64'd0);
                chk("rst_out_err", 64'(out_err), 64'd0);
                chk("rst_vrf_rdata", 64'(vrf_rdata), 64'd0);
                chk("rst_mst_ctrl", {60'd0, xif.dec_req_valid, xif.dec_rsp_ready, xif.exe_req_valid, xif.exe_rsp_ready}, 64'd0);
                hit = 1;
            end else begin
                tick();
            end
        end
        chk("reached_exe", 64'(hit), 64'd1);
        slv_idle();
        for (int i = 0; i < NumVRegs; i++) mvrf[i] = '0;
        sbq.delete();
        tick();
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("no_stale_out_valid", 64'(out_valid), 64'd0);
        end
    endtask

    initial begin : stim
        logic [31:0] ins;
        logic [IdWidth-1:0] rid;
        logic acc, clob, mis;
        rst = 1'b1;
        slv_idle();
        in_id = '0; in_instr = '0; in_rs_data = '0; vrf_addr = '0; vrf_wdata = '0;
        for (int i = 0; i < NumVRegs; i++) mvrf[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_in_ready", 64'(in_ready), 64'd0);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_vrf_rdata", 64'(vrf_rdata), 64'd0);
        chk("reset_mst_ctrl", {60'd0, xif.dec_req_valid, xif.dec_rsp_ready, xif.exe_req_valid, xif.exe_rsp_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("in_ready_first_cycle", 64'(in_ready), 64'd1);
        tick();

        // Decode rejected
        run_txn(4'h1, 32'h0, 32'h11, 32'h22, 1'b0, 1'b0, 4'h1, 4'h1, 0, 0, 0, 1'b0, 1'b0, 32'h0, 2);
        read_const("reject_vrf0", 5'd0, 32'd0);

        // Execute with write-back
        host_write(5'd1, 32'd5);
        host_write(5'd2, 32'd7);
        host_write(5'd3, 32'd2);
        run_txn(4'h2, mk(5'd3, 5'd1, 5'd2), 32'hA, 32'hB, 1'b1, 1'b1, 4'h2, 4'h2, 0, 0, 0, 1'b0, 1'b0, 32'h0, 3);
        read_const("wb_vrf3", 5'd3, 32'd37);

        // Delayed responder
        host_write(5'd3, 32'd2);
        run_txn(4'h3, mk(5'd3, 5'd1, 5'd2), 32'h1, 32'h2, 1'b1, 1'b1, 4'h3, 4'h3, 3, 4, 0, 1'b0, 1'b0, 32'h0, -1);
        read_const("delayed_vrf3", 5'd3, 32'd37);

        // Id mismatch, then a clean instruction
        run_txn(4'h4, mk(5'd6, 5'd1, 5'd2), 32'h0, 32'h0, 1'b1, 1'b1, 4'h5, 4'h5, 0, 0, 0, 1'b0, 1'b0, 32'h0, -1);
        read_const("mismatch_vrf6", 5'd6, 32'd35);
        run_txn(4'h7, mk(5'd9, 5'd2, 5'd2), 32'h0, 32'h0, 1'b1, 1'b1, 4'h7, 4'h7, 0, 0, 0, 1'b0, 1'b0, 32'h0, -1);
        read_const("clean_vrf9", 5'd9, 32'd49);

        // Backpressure on out and host write attempted during EXE
        run_txn(4'h8, mk(5'd10, 5'd1, 5'd2), 32'h5, 32'h6, 1'b1, 1'b1, 4'h8, 4'h8, 0, 2, 5, 1'b1, 1'b0, 32'h0, -1);
        read_const("lockout_vrf1", 5'd1, 32'd5);

        // Host write in the same cycle as the instruction handshake
        run_txn(4'h9, mk(5'd8, 5'd1, 5'd2), 32'h0, 32'h0, 1'b1, 1'b1, 4'h9, 4'h9, 0, 0, 0, 1'b0, 1'b1, 32'd3, 3);
        read_const("same_cycle_vrf8", 5'd8, 32'd21);

        for (int t = 0; t < 40; t++) begin
            host_write(5'($urandom_range(0, 31)), $urandom_range(0, 1000));
            host_write(5'($urandom_range(0, 31)), $urandom);
            ins  = $urandom;
            acc  = ($urandom_range(0, 3) != 0);
            clob = $urandom_range(0, 1);
            mis  = ($urandom_range(0, 7) == 0);
            rid  = 4'($urandom_range(0, 15));
            run_txn(rid, ins, $urandom, $urandom, acc, clob,
                    mis ? rid + 4'd1 : rid, mis ? rid ^ 4'h8 : rid,
                    $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                    ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0), $urandom, -1);
            read_model(ins[11:7]);
            read_model(ins[19:15]);
        end

        // Reset while exe_req is pending
        host_write(5'd4, 32'd9);
        host_write(5'd5, 32'd4);
        reset_mid_exe(4'hC, mk(5'd4, 5'd4, 5'd5));
        read_model(5'd4);
        read_model(5'd5);
        run_txn(4'hD, mk(5'd4, 5'd4, 5'd5), 32'h0, 32'h0, 1'b1, 1'b1, 4'hD, 4'hD, 0, 0, 0, 1'b0, 1'b0, 32'h0, 3);
        read_model(5'd4);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/xadac_issue.md
# xadac_issue

Initiator (master) end of the xadac accelerator interface. Accepts offloaded custom-vector instructions one at a time from a CPU-side valid/ready stream, drives the decode phase and then the execute phase toward any xadac responder (e.g. the vector multiply-accumulate unit), and writes results into a local 32-entry vector register file (VRF). Sits between the core's offload port and the accelerator slaves. A host port preloads and inspects the VRF.

## Interface
- Widths (`VecDataWidth`, id and instr widths) come from `xadac_pkg`; no local parameters.
- `NumVRegs`, 32: VRF depth, addressed by 5-bit fields.
- `clk`  in  1  clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `mst`  xadac_if.mst  —  drives `dec_req*`, `dec_rsp_ready`, `exe_req*`, `exe_rsp_ready`.
- `in_valid` / `in_ready`  in / out  1 each  instruction handshake.
- `in_id`  in  id width  transaction id.
- `in_instr`  in  32  instruction word.
- `in_rs_data`  in  2 x 32  scalar operands, forwarded in `exe_req`.
- `out_valid` / `out_ready`  out / in  1 each  completion handshake.
- `out_id`  out  id width  id of the completed instruction.
- `out_accept`  out  1  `dec_rsp.accept` as received.
- `out_err`  out  1  a response id did not match the latched id.
- `vrf_we`  in  1  host VRF write strobe.
- `vrf_addr`  in  5  host VRF address.
- `vrf_wdata`  in  `VecDataWidth`  host write data.
- `vrf_rdata`  out  `VecDataWidth`  `VRF[vrf_addr]`, registered, 1-cycle latency.

## Operation
- FSM states: IDLE, DEC, EXE, DONE. One instruction in flight at a time.
- **IDLE**
  - `in_ready` = 1. On `in_valid && in_ready`, latch id, instr and rs_data, clear the handshake flags, and go to DEC.
  - Host writes are honoured only in IDLE. In other states `vrf_we` is ignored.
- **DEC**
  - `dec_req_valid` = !req_done; `dec_req.id` and `dec_req.instr` come from the latches.
  - `dec_rsp_ready` = !rsp_done. It is asserted together with `dec_req_valid`, because responders may tie req_ready to the rsp handshake.
  - Set req_done on the req handshake. On the rsp handshake, set rsp_done and latch `vd_clobber` and `accept`.
  - When both flags are set (same cycle allowed), clear the flags. Then:
    - `accept` = 0: go to DONE.
    - `accept` = 1: go to EXE.
- **EXE**
  - `exe_req_valid` = !req_done; `exe_req.id` and `exe_req.instr` come from the latches; `rs_data` is the latched `in_rs_data`.
  - VRF reads for `exe_req.vs_data`, held stable while valid:
    - `vs_data[0]` = `VRF[instr[19:15]]`
    - `vs_data[1]` = `VRF[instr[24:20]]`
    - `vs_data[2]` = `VRF[instr[11:7]]`
  - `exe_rsp_ready` = !rsp_done; same req/rsp flag scheme as DEC.
  - On the rsp handshake, if `vd_clobber` was latched, write `VRF[exe_rsp.vd_addr]` ← `exe_rsp.vd_data`.
  - Go to DONE when both flags are set.
- **DONE**
  - `out_valid` = 1. Hold `out_id`, `out_accept` and `out_err` stable until `out_ready`, then return to IDLE.
- **Id check**
  - Set `out_err` if `dec_rsp.id` or `exe_rsp.id` differs from the latched id. Keep it set until DONE exits.
  - A mismatch does not block the FSM; the VRF write still occurs.
- Same-cycle `vrf_we` and `in_valid` in IDLE: both take effect; the write is visible to the EXE-phase reads.

## Timing
- Reset (async assert) returns the FSM to IDLE and, for the duration of reset:
  - all `mst` valids and readies = 0; `in_ready` = 0;
  - `out_valid`, `out_accept`, `out_err` = 0; `vrf_rdata` = 0;
  - VRF cleared to 0.
- `in_ready` = 1 from the first cycle after deassertion.
- A reset during DEC or EXE abandons the transaction: no VRF write and no completion.
- Minimum latency against a same-cycle responder, counted from the cycle after the `in` handshake:
  - accepted instruction: DEC 1 cycle, EXE 1 cycle, `out_valid` in cycle 3;
  - rejected instruction: `out_valid` in cycle 2.
- The EXE-response VRF write is visible on `vrf_rdata` 1 cycle after returning to IDLE, given the host address is set then.
- `dec_req_valid` and `exe_req_valid` never deassert before their handshake, and their payloads do not change while valid.

## Test plan
- **Decode rejected**: instr 0x0000_0000, stub returns accept = 0 -> `out_accept` = 0, no `exe_req_valid` pulse, VRF unchanged, `out_valid` 2 cycles after `in`.
- **Execute with write-back**:
  - Setup: host writes `VRF[1]` = 5, `VRF[2]` = 7, `VRF[3]` = 2; issue instr with vs1 = 1, vs2 = 2, vd = 3; stub responder returns `vd_data` = vs0·vs1 + vs2.
  - Required: `exe_req.vs_data` = {5, 7, 2}; afterwards `VRF[3]` = 37; `out_accept` = 1; `out_err` = 0.
- **Delayed responder**: dec_rsp 3 cycles after the req handshake; exe_req_ready held low for 4 cycles -> no duplicate handshakes, exe payload stable throughout, same VRF result as the previous scenario.
- **Id mismatch**: stub echoes id 0x5 for latched id 0x4 -> `out_err` = 1 at DONE, VRF written; next instruction completes with `out_err` = 0.
- **Backpressure and host lockout**: hold `out_ready` = 0 for 5 cycles -> `out_valid` held and `in_ready` = 0. Issue `vrf_we` during EXE -> write ignored.
- **Reset mid-EXE**: assert `rst` while `exe_req_valid` = 1 -> all outputs and the VRF are 0 immediately; after release, `in_ready` = 1 and no stale completion appears.
